router_vc_input_buffer: RTL and testbench

Parametrised input-port buffer for the mesh router, one instance per input port (up, down, left, right, NIC). It replaces the single-slot, single-VC input register with NUM_VC virtual-channel FIFOs of DEPTH flits each. Each incoming flit is steered to a FIFO by the VC field of the flit. The block exposes one FIFO head per VC to the router's switch allocator. It also adds per-VC ready, per-VC occupancy, and sticky overflow detection.

---
 rtl/router_vc_input_buffer_if.sv | 43 ++++
 rtl/router_vc_input_buffer.sv | 108 ++++++++++
 tb/tb_router_vc_input_buffer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/router_vc_input_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : router_vc_input_buffer_if
// Description : Bundle between one router input port, its upstream sender
//               and the switch allocator.
//               si/di       - upstream send strobe and flit
//               ri          - per-VC ready (FIFO not full)
//               out_valid   - per-VC head valid
//               out_data    - per-VC head flit, DATA_W bits per VC
//               out_pop     - per-VC head consume from the switch allocator
//               count       - per-VC occupancy, CW bits per VC
//               overflow    - sticky flit-dropped flag
//               The master modport is the sender/allocator side. The slave
//               modport is the buffer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface router_vc_input_buffer_if #(
    parameter int DATA_W = 64,
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     si;
    logic [DATA_W-1:0]        di;
    logic [NUM_VC-1:0]        ri;
    logic [NUM_VC-1:0]        out_valid;
    logic [NUM_VC*DATA_W-1:0] out_data;
    logic [NUM_VC-1:0]        out_pop;
    logic [NUM_VC*CW-1:0]     count;
    logic                     overflow;

    modport master (
        output si, di, out_pop,
        input  ri, out_valid, out_data, count, overflow
    );

    modport slave (
        input  si, di, out_pop,
        output ri, out_valid, out_data, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/router_vc_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : router_vc_input_buffer
// Description : Router input-port buffer with NUM_VC virtual-channel FIFOs of
//               DEPTH flits each. The flit's VC field di[VC_MSB -: VCW]
//               steers it to a FIFO. Each FIFO head is presented
//               first-word-fall-through. A flit sent to a full FIFO is
//               dropped, and the sticky overflow flag is set.
//               Ports: clk   - clock, rising edge
//                      reset - asynchronous active-low reset
//                      bus   - router_vc_input_buffer_if.slave (see interface)
// Revision    : 1.0 - initial release
// ============================================================================
module router_vc_input_buffer #(
    parameter int DATA_W = 64,
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 4,
    parameter int VC_MSB = 63
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    router_vc_input_buffer_if.slave       bus
);
    localparam int VCW = $clog2(NUM_VC);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    logic [VCW-1:0]           w_vc;
    logic [NUM_VC-1:0]        w_full;
    logic                     w_drop;
    logic                     r_overflow;
    logic [NUM_VC-1:0]        w_ri;
    logic [NUM_VC-1:0]        w_out_valid;
    logic [NUM_VC*DATA_W-1:0] w_out_data;
    logic [NUM_VC*CW-1:0]     w_count;

    assign w_vc = bus.di[VC_MSB -: VCW];

    // Acceptance uses only the pre-edge count. A pop in the same cycle
    // does not free space for a push to a full FIFO.
    assign w_drop = bus.si && w_full[w_vc];

    generate
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [PW-1:0]     r_wr_ptr;
            logic [PW-1:0]     r_rd_ptr;
            logic [CW-1:0]     r_count;
            logic              w_push;
            logic              w_pop;

            assign w_full[v] = (r_count == c_full);
            assign w_push    = bus.si && (w_vc == VCW'(v)) && !w_full[v];
            assign w_pop     = bus.out_pop[v] && (r_count != '0);

            // Storage is not reset; the count decides what is valid.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= bus.di;
                end
            end

            // DEPTH is a power of two, so the natural pointer wrap is
            // modulo DEPTH.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    if (w_push && !w_pop) begin
                        r_count <= r_count + 1'b1;
                    end else if (w_pop && !w_push) begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end

            assign w_ri[v]                        = !w_full[v];
            assign w_out_valid[v]                 = (r_count != '0);
            assign w_out_data[v*DATA_W +: DATA_W] = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
            assign w_count[v*CW +: CW]            = r_count;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.ri        = w_ri;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.count     = w_count;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_router_vc_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_vc_input_buffer
// Description : Directed self-checking bench for router_vc_input_buffer.
//               It uses NUM_VC=2, DEPTH=4, DATA_W=64 and VC_MSB=63.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_vc_input_buffer;
    localparam int DATA_W = 64;
    localparam int NUM_VC = 2;
    localparam int DEPTH  = 4;
    localparam int VC_MSB = 63;
    localparam int CW     = 3;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    router_vc_input_buffer_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH)) bus ();

    router_vc_input_buffer #(
        .DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH), .VC_MSB(VC_MSB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] head(input int v);
        return bus.out_data[v*DATA_W +: DATA_W];
    endfunction

    function automatic logic [63:0] cnt(input int v);
        return 64'(bus.count[v*CW +: CW]);
    endfunction

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic s, input logic [63:0] d, input logic [1:0] p);
        bus.si      = s;
        bus.di      = d;
        bus.out_pop = p;
        @(posedge clk);
        #1;
        bus.si      = 1'b0;
        bus.di      = '0;
        bus.out_pop = '0;
    endtask

    logic [63:0] seq [10];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.si      = 1'b0;
        bus.di      = '0;
        bus.out_pop = '0;

        // 1. Reset with random inputs applied
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.si      = 1'($urandom_range(0, 1));
            bus.di      = {$urandom, $urandom};
            bus.out_pop = 2'($urandom_range(0, 3));
        end
        check("rst_valid", 64'(bus.out_valid), 64'h0);
        check("rst_ri", 64'(bus.ri), 64'h3);
        check("rst_count", 64'(bus.count), 64'h0);
        check("rst_ovf", 64'(bus.overflow), 64'h0);
        check("rst_data", bus.out_data[63:0] | bus.out_data[127:64], 64'h0);
        bus.si = 1'b0; bus.di = '0; bus.out_pop = '0;
        reset = 1'b1;

        // 2. Steering by VC field
        step(1'b1, 64'h8003_0000_0000_0000, 2'b00);
        step(1'b1, 64'h000c_0000_0000_0000, 2'b00);
        check("steer_valid", 64'(bus.out_valid), 64'h3);
        check("steer_head1", head(1), 64'h8003_0000_0000_0000);
        check("steer_head0", head(0), 64'h000c_0000_0000_0000);
        check("steer_cnt0", cnt(0), 64'd1);
        check("steer_cnt1", cnt(1), 64'd1);
        step(1'b0, 64'h0, 2'b11);
        check("steer_drain", 64'(bus.out_valid), 64'h0);

        // 3. Fill VC0, drop the fifth flit, then drain
        for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 2'b00);
        check("full_ri", 64'(bus.ri), 64'h2);
        check("full_cnt0", cnt(0), 64'd4);
        check("full_ovf_pre", 64'(bus.overflow), 64'h0);
        step(1'b1, 64'd5, 2'b00);
        check("drop_ovf", 64'(bus.overflow), 64'h1);
        check("drop_cnt0", cnt(0), 64'd4);
        check("drop_ri1", 64'(bus.ri[1]), 64'h1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_head", head(0), 64'(i));
            step(1'b0, 64'h0, 2'b01);
            if (i == 1) check("ri_rise", 64'(bus.ri), 64'h3);
        end
        check("drain_empty", 64'(bus.out_valid), 64'h0);
        check("drain_zero", head(0), 64'h0);
        step(1'b0, 64'h0, 2'b01);
        check("pop_empty_cnt", cnt(0), 64'd0);
        check("ovf_sticky", 64'(bus.overflow), 64'h1);

        // 4. Simultaneous push and pop at count 2
        step(1'b1, 64'h0000_0000_0000_00AA, 2'b00);
        step(1'b1, 64'h0000_0000_0000_00BB, 2'b00);
        step(1'b1, 64'h0000_0000_0000_00CC, 2'b01);
        check("pp_cnt", cnt(0), 64'd2);
        check("pp_head", head(0), 64'h0000_0000_0000_00BB);
        step(1'b0, 64'h0, 2'b01);
        check("pp_next", head(0), 64'h0000_0000_0000_00CC);
        step(1'b0, 64'h0, 2'b01);
        check("pp_empty", cnt(0), 64'd0);

        // Clear the sticky flag before the wrap test.
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 5. Wrap-around on VC1 with a one-cycle pop lag
        for (int i = 0; i < 10; i++) seq[i] = 64'h8000_0000_0000_0100 + 64'(i * 7);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, seq[i], (i == 0) ? 2'b00 : 2'b10);
            check("wrap_head", head(1), seq[i]);
            check("wrap_cnt", cnt(1), 64'd1);
        end
        step(1'b0, 64'h0, 2'b10);
        check("wrap_empty", 64'(bus.out_valid), 64'h0);
        check("wrap_ovf", 64'(bus.overflow), 64'h0);

        // 6. Asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1'b1, 64'h0000_0000_0000_0DD0 + 64'(i), 2'b00);
        check("mid_cnt3", cnt(0), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check("async_cnt", 64'(bus.count), 64'h0);
        check("async_valid", 64'(bus.out_valid), 64'h0);
        check("async_data", head(0), 64'h0);
        check("async_ri", 64'(bus.ri), 64'h3);
        #1;
        reset = 1'b1;
        step(1'b1, 64'h0000_0000_0000_0EE1, 2'b00);
        check("post_head", head(0), 64'h0000_0000_0000_0EE1);
        check("post_cnt", cnt(0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
